linebuffer_pp: RTL and testbench



---
 rtl/linebuffer_pp.sv | 129 ++++++++++++
 tb/tb_linebuffer_pp.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/linebuffer_pp.sv
// Ping-pong line buffer: one bank fills while the other is scanned out,
// with independent horizontal and vertical pixel repeat.
module linebuffer_pp #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3,
    parameter int LEN      = 640,
    parameter int SCALE_H  = 1,
    parameter int SCALE_V  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame,
    input  logic                      line,
    input  logic                      en_out,
    input  logic                      en_in,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic                      data_req,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      underrun
);

    localparam int DW = CHANNELS * WIDTH;
    localparam int AW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int HW = (SCALE_H > 1) ? $clog2(SCALE_H) : 1;
    localparam int VW = (SCALE_V > 1) ? $clog2(SCALE_V) : 1;

    localparam logic [AW-1:0] A_LAST = AW'(LEN - 1);
    localparam logic [HW-1:0] H_LAST = HW'(SCALE_H - 1);
    localparam logic [VW-1:0] V_LAST = VW'(SCALE_V - 1);

    logic [DW-1:0] bank0 [LEN];
    logic [DW-1:0] bank1 [LEN];

    logic          wr_bank;
    logic          wr_full;
    logic [AW-1:0] addr_in;
    logic          rd_valid;
    logic [AW-1:0] addr_out;
    logic [HW-1:0] cnt_h;
    logic [VW-1:0] cnt_v;
    logic          set_end;
    logic [DW-1:0] rd_q;
    logic [DW-1:0] rd_word;
    logic          wr_en;

    assign wr_en = en_in && !wr_full && !frame;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_bank) bank1[addr_in] <= din;
            else         bank0[addr_in] <= din;
        end
    end

    // The read bank is always the one not being written.
    assign rd_word = wr_bank ? bank0[addr_out] : bank1[addr_out];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank  <= 1'b0;
            wr_full  <= 1'b0;
            addr_in  <= '0;
            rd_valid <= 1'b0;
            addr_out <= '0;
            cnt_h    <= '0;
            cnt_v    <= '0;
            set_end  <= 1'b0;
            rd_q     <= '0;
            data_req <= 1'b0;
            underrun <= 1'b0;
        end else begin
            data_req <= 1'b0;
            if (frame) begin
                cnt_h    <= '0;
                cnt_v    <= '0;
                addr_out <= '0;
                set_end  <= 1'b1;
                rd_valid <= 1'b0;
                addr_in  <= '0;
                wr_full  <= 1'b0;
                underrun <= 1'b0;
                rd_q     <= '0;
                data_req <= 1'b1;
            end else begin
                if (en_in && !wr_full) begin
                    if (addr_in == A_LAST) begin
                        wr_full <= 1'b1;
                        addr_in <= '0;
                    end else begin
                        addr_in <= addr_in + 1'b1;
                    end
                end
                if (line && set_end) begin
                    set_end <= 1'b0;
                    if (wr_full) begin
                        wr_bank  <= ~wr_bank;
                        wr_full  <= 1'b0;
                        addr_in  <= '0;
                        rd_valid <= 1'b1;
                        data_req <= 1'b1;
                    end else begin
                        underrun <= 1'b1;
                    end
                end else if (en_out && !set_end) begin
                    rd_q <= rd_valid ? rd_word : '0;
                    if (cnt_h == H_LAST) begin
                        cnt_h <= '0;
                        if (addr_out == A_LAST) begin
                            addr_out <= '0;
                            if (cnt_v == V_LAST) begin
                                cnt_v   <= '0;
                                set_end <= 1'b1;
                            end else begin
                                cnt_v <= cnt_v + 1'b1;
                            end
                        end else begin
                            addr_out <= addr_out + 1'b1;
                        end
                    end else begin
                        cnt_h <= cnt_h + 1'b1;
                    end
                end
            end
        end
    end

    assign dout = rd_q;

endmodule

// File: tb/tb_linebuffer_pp.sv
// Directed bench for linebuffer_pp: unscaled table walk plus a 2x2
// scaled instance and an asynchronous reset check.
module tb_linebuffer_pp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        frame0 = 0, line0 = 0, en_out0 = 0, en_in0 = 0;
    logic [15:0] din0 = '0;
    logic        data_req0, underrun0;
    logic [15:0] dout0;

    logic        frame1 = 0, line1 = 0, en_out1 = 0, en_in1 = 0;
    logic [15:0] din1 = '0;
    logic        data_req1, underrun1;
    logic [15:0] dout1;

    linebuffer_pp #(.WIDTH(8), .CHANNELS(2), .LEN(4),
                    .SCALE_H(1), .SCALE_V(1)) u0 (
        .clk(clk), .rst_n(rst_n), .frame(frame0), .line(line0),
        .en_out(en_out0), .en_in(en_in0), .din(din0),
        .data_req(data_req0), .dout(dout0), .underrun(underrun0));

    linebuffer_pp #(.WIDTH(8), .CHANNELS(2), .LEN(4),
                    .SCALE_H(2), .SCALE_V(2)) u1 (
        .clk(clk), .rst_n(rst_n), .frame(frame1), .line(line1),
        .en_out(en_out1), .en_in(en_in1), .din(din1),
        .data_req(data_req1), .dout(dout1), .underrun(underrun1));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        fr;
        logic        ln;
        logic        wi;
        logic [15:0] di;
        logic        ro;
        logic [15:0] q;
        logic        rq;
        logic        ur;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic fr, input logic ln,
                               input logic wi, input logic [15:0] di,
                               input logic ro, input logic [15:0] q,
                               input logic rq, input logic ur);
        vec_t r;
        r.fr = fr; r.ln = ln; r.wi = wi; r.di = di;
        r.ro = ro; r.q = q; r.rq = rq; r.ur = ur;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            frame0  = vq[i].fr;
            line0   = vq[i].ln;
            en_in0  = vq[i].wi;
            din0    = vq[i].di;
            en_out0 = vq[i].ro;
            cyc();
            chk($sformatf("row%0d dout", i), dout0, vq[i].q);
            chk($sformatf("row%0d data_req", i), 16'(data_req0), 16'(vq[i].rq));
            chk($sformatf("row%0d underrun", i), 16'(underrun0), 16'(vq[i].ur));
        end
        frame0 = 0; line0 = 0; en_in0 = 0; en_out0 = 0; din0 = '0;
    endtask

    initial begin
        //                fr ln wi din       ro dout      rq ur
        vq.push_back(v(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 0)); // 0 frame
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0101, 0, 16'h0000, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0202, 0, 16'h0000, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0303, 0, 16'h0000, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0404, 0, 16'h0000, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0505, 0, 16'h0000, 0, 0)); // overfill
        vq.push_back(v(0, 0, 1, 16'h0606, 0, 16'h0000, 0, 0));
        vq.push_back(v(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0)); // 8 swap A
        vq.push_back(v(0, 0, 1, 16'h0010, 1, 16'h0101, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0011, 1, 16'h0202, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0012, 1, 16'h0303, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0013, 1, 16'h0404, 0, 0));
        vq.push_back(v(0, 0, 0, 16'h0000, 1, 16'h0404, 0, 0)); // 13 hold
        vq.push_back(v(0, 1, 0, 16'h0000, 0, 16'h0404, 1, 0)); // swap B
        vq.push_back(v(0, 0, 1, 16'h0020, 1, 16'h0010, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0021, 1, 16'h0011, 0, 0));
        vq.push_back(v(0, 0, 0, 16'h0000, 1, 16'h0012, 0, 0));
        vq.push_back(v(0, 0, 0, 16'h0000, 1, 16'h0013, 0, 0));
        vq.push_back(v(0, 1, 0, 16'h0000, 0, 16'h0013, 0, 1)); // underrun
        vq.push_back(v(0, 0, 0, 16'h0000, 1, 16'h0010, 0, 1));
        vq.push_back(v(0, 0, 0, 16'h0000, 1, 16'h0011, 0, 1));
        vq.push_back(v(0, 0, 1, 16'h0022, 1, 16'h0012, 0, 1));
        vq.push_back(v(0, 0, 1, 16'h0023, 1, 16'h0013, 0, 1));
        vq.push_back(v(0, 1, 0, 16'h0000, 0, 16'h0013, 1, 1)); // swap C
        vq.push_back(v(0, 0, 0, 16'h0000, 1, 16'h0020, 0, 1));
        vq.push_back(v(1, 1, 1, 16'h0099, 0, 16'h0000, 1, 0)); // frame wins
        vq.push_back(v(0, 0, 1, 16'h0031, 1, 16'h0000, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0032, 0, 16'h0000, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0033, 0, 16'h0000, 0, 0));
        vq.push_back(v(0, 0, 1, 16'h0034, 0, 16'h0000, 0, 0));
        vq.push_back(v(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0));
        vq.push_back(v(0, 0, 0, 16'h0000, 1, 16'h0031, 0, 0));
        vq.push_back(v(0, 0, 0, 16'h0000, 1, 16'h0032, 0, 0)); // 33

        #2;
        chk("reset dout", dout0, 16'h0000);
        chk("reset data_req", 16'(data_req0), 16'h0000);
        chk("reset underrun", 16'(underrun0), 16'h0000);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        run_rows(0, 33);

        // 2x2 scaled instance: each pixel twice, line twice
        frame1 = 1;
        cyc();
        frame1 = 0;
        chk("s frame data_req", 16'(data_req1), 16'h0001);
        for (int i = 0; i < 4; i++) begin
            en_in1 = 1;
            din1 = 16'(i + 1);
            cyc();
        end
        en_in1 = 0;
        line1 = 1;
        cyc();
        line1 = 0;
        chk("s swap data_req", 16'(data_req1), 16'h0001);
        chk("s swap dout", dout1, 16'h0000);
        for (int k = 0; k < 18; k++) begin
            en_out1 = 1;
            cyc();
            if (k < 16)
                chk($sformatf("s out%0d", k), dout1, 16'((k % 8) / 2 + 1));
            else
                chk($sformatf("s hold%0d", k), dout1, 16'h0004);
        end
        en_out1 = 0;
        chk("s underrun", 16'(underrun1), 16'h0000);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async dout0", dout0, 16'h0000);
        chk("async dout1", dout1, 16'h0000);
        chk("async data_req", 16'(data_req0), 16'h0000);
        chk("async underrun", 16'(underrun0), 16'h0000);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        run_rows(0, 13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
